// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 frame driver: state encoding and default timing.
// Timing defaults assume a 20 MHz clk (50 ns per cycle).
package ws2812_pkg;

    localparam int DEF_NUM_BITS = 120;
    localparam int DEF_T_PERIOD = 25;
    localparam int DEF_T0H      = 8;
    localparam int DEF_T1H      = 16;
    localparam int DEF_T_RESET  = 1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_BIT   = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    // Width of a counter that must reach max(a,b)-1.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Cycle counter shared by the bit and latch phases, plus the high/low decision for the current bit.
module ws2812_bit_timer #(
    parameter int CW  = 10,
    parameter int T0H = 8,
    parameter int T1H = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clr,
    input  logic          i_bit_phase,
    input  logic          i_bit,
    output logic [CW-1:0] o_cyc_cnt,
    output logic          o_dout_next
);

    localparam logic [CW-1:0] L_T0H = CW'(T0H);
    localparam logic [CW-1:0] L_T1H = CW'(T1H);

    logic [CW-1:0] r_cyc_cnt;
    logic [CW-1:0] w_high_len;

    always_ff @(posedge clk) begin
        if (reset || i_clr)
            r_cyc_cnt <= '0;
        else
            r_cyc_cnt <= r_cyc_cnt + CW'(1);
    end

    assign w_high_len  = i_bit ? L_T1H : L_T0H;
    assign o_dout_next = i_bit_phase && (r_cyc_cnt < w_high_len);
    assign o_cyc_cnt   = r_cyc_cnt;

endmodule

// File: rtl/ws2812_frame_driver.sv
// WS2812 frame driver: walks an external GRB shift register bit by bit, emits the pulse train,
// then holds the line low for the latch time. Reset always ends in a full latch period.
module ws2812_frame_driver
    import ws2812_pkg::*;
#(
    parameter int NUM_BITS = DEF_NUM_BITS,
    parameter int T_PERIOD = DEF_T_PERIOD,
    parameter int T0H      = DEF_T0H,
    parameter int T1H      = DEF_T1H,
    parameter int T_RESET  = DEF_T_RESET
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic current_bit,
    output logic load_register,
    output logic rotate_register_left,
    output logic dout,
    output logic busy,
    output logic done
);

    localparam int CW = cnt_width(T_PERIOD, T_RESET);
    localparam int BW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

    localparam logic [CW-1:0] L_PER_END  = CW'(T_PERIOD - 1);
    localparam logic [CW-1:0] L_RST_END  = CW'(T_RESET - 1);
    localparam logic [BW-1:0] L_LAST_BIT = BW'(NUM_BITS - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic [BW-1:0] r_bit_cnt;
    logic          r_frame_flag;
    logic          r_dout;
    logic [CW-1:0] w_cyc_cnt;
    logic          w_dout_next;
    logic          w_bit_end;
    logic          w_latch_end;
    logic          w_last_bit;
    logic          w_cyc_clr;

    assign w_bit_end   = (r_state == ST_BIT) && (w_cyc_cnt == L_PER_END);
    assign w_latch_end = (r_state == ST_LATCH) && (w_cyc_cnt == L_RST_END);
    assign w_last_bit  = (r_bit_cnt == L_LAST_BIT);
    // The counter is parked at 0 outside BIT/LATCH so each phase starts from a clean count.
    assign w_cyc_clr   = w_bit_end || w_latch_end || (r_state == ST_IDLE) || (r_state == ST_LOAD);

    ws2812_bit_timer #(
        .CW  (CW),
        .T0H (T0H),
        .T1H (T1H)
    ) u_bit_timer (
        .clk         (clk),
        .reset       (reset),
        .i_clr       (w_cyc_clr),
        .i_bit_phase (r_state == ST_BIT),
        .i_bit       (current_bit),
        .o_cyc_cnt   (w_cyc_cnt),
        .o_dout_next (w_dout_next)
    );

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_LATCH;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_LOAD;
            ST_LOAD:  w_state_next = ST_BIT;
            ST_BIT:   if (w_bit_end && w_last_bit) w_state_next = ST_LATCH;
            ST_LATCH: if (w_latch_end) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        load_register        = (r_state == ST_LOAD);
        rotate_register_left = w_bit_end;
        done                 = w_latch_end && r_frame_flag;
        busy                 = (r_state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt    <= '0;
            r_frame_flag <= 1'b0;
            r_dout       <= 1'b0;
        end else begin
            r_dout <= w_dout_next;
            if (r_state == ST_LOAD)
                r_bit_cnt <= '0;
            else if (w_bit_end)
                r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + BW'(1);
            if ((r_state == ST_IDLE) && start)
                r_frame_flag <= 1'b1;
            else if (w_latch_end)
                r_frame_flag <= 1'b0;
        end
    end

    assign dout = r_dout;

endmodule

// File: tb/tb_ws2812_frame_driver.sv
// Bench for ws2812_frame_driver: behavioural shift register, pulse-train measurement per frame,
// table of GRB patterns plus hand sequences for restart, reset and back-to-back corner cases.
`timescale 1ns/1ps
module tb_ws2812_frame_driver;

    localparam int NB  = 120, TP  = 25, T0  = 8, T1  = 16, TR  = 1000;
    localparam int NB2 = 24,  TP2 = 10, T02 = 3, T12 = 6,  TR2 = 20;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic start  = 1'b0;
    logic start2 = 1'b0;
    always #5 clk = ~clk;

    logic [NB-1:0]  grb  = '0;
    logic [NB-1:0]  sr   = '0;
    logic [NB2-1:0] grb2 = '0;
    logic [NB2-1:0] sr2  = '0;
    logic load_register, rotate_register_left, dout, busy, done;
    logic load2, rot2, dout2, busy2, done2;

    always @(posedge clk) begin
        if (load_register) sr <= grb;
        else if (rotate_register_left) sr <= {sr[NB-2:0], sr[NB-1]};
        if (load2) sr2 <= grb2;
        else if (rot2) sr2 <= {sr2[NB2-2:0], sr2[NB2-1]};
    end

    ws2812_frame_driver dut (
        .clk(clk), .reset(reset), .start(start), .current_bit(sr[NB-1]),
        .load_register(load_register), .rotate_register_left(rotate_register_left),
        .dout(dout), .busy(busy), .done(done)
    );

    ws2812_frame_driver #(.NUM_BITS(NB2), .T_PERIOD(TP2), .T0H(T02), .T1H(T12), .T_RESET(TR2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .current_bit(sr2[NB2-1]),
        .load_register(load2), .rotate_register_left(rot2),
        .dout(dout2), .busy(busy2), .done(done2)
    );

    bit   sel = 1'b0;
    logic m_busy, m_load, m_rot, m_dout, m_done;
    assign m_busy = sel ? busy2 : busy;
    assign m_load = sel ? load2 : load_register;
    assign m_rot  = sel ? rot2  : rotate_register_left;
    assign m_dout = sel ? dout2 : dout;
    assign m_done = sel ? done2 : done;

    typedef struct {
        logic [NB-1:0] pat;
        int            ones;
        int            first_w;
        int            last_w;
    } vec_t;
    vec_t vecs[4];

    int n_vec = 0, n_err = 0;
    int cyc = 0;
    int busy_n, loads, rots, dones, done_at, load_at, first_rise, last_rise;
    int hi, pulses, ones, first_w, last_w, width_err, period_err, gaps, gap_err, last_rot_cyc;
    int cur_nb, cur_tp, cur_t0, cur_t1, cur_tr;
    logic [NB-1:0] exp_pat;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start2 = v;
        else     start  = v;
    endtask

    task automatic clear_stats();
        busy_n = 0; loads = 0; rots = 0; dones = 0; done_at = 0; load_at = 0;
        first_rise = 0; last_rise = 0; hi = 0; pulses = 0; ones = 0; first_w = 0; last_w = 0;
        width_err = 0; period_err = 0; gaps = 0; gap_err = 0; last_rot_cyc = 0;
        cur_nb = sel ? NB2 : NB;  cur_tp = sel ? TP2 : TP;  cur_t0 = sel ? T02 : T0;
        cur_t1 = sel ? T12 : T1;  cur_tr = sel ? TR2 : TR;
    endtask

    task automatic sample_cycle();
        int  idx;
        int  exp_w;
        @(negedge clk);
        cyc++;
        if (m_busy) busy_n++;
        if (m_load) begin
            loads++;
            if (load_at == 0) load_at = busy_n;
            if (last_rot_cyc > 0) begin
                gaps++;
                if (cyc - last_rot_cyc - 1 != cur_tr + 1) gap_err++;
            end
        end
        if (m_rot) begin
            rots++;
            last_rot_cyc = cyc;
        end
        if (m_done) begin
            dones++;
            done_at = busy_n;
        end
        if (m_dout) begin
            if (hi == 0) begin
                if (first_rise == 0) first_rise = busy_n;
                else if (busy_n - last_rise != cur_tp) period_err++;
                last_rise = busy_n;
            end
            hi++;
        end else if (hi > 0) begin
            pulses++;
            idx   = cur_nb - pulses;
            exp_w = (idx >= 0 && exp_pat[idx]) ? cur_t1 : cur_t0;
            if (hi != exp_w) width_err++;
            if (hi == cur_t1) ones++;
            if (pulses == 1) first_w = hi;
            last_w = hi;
            hi = 0;
        end
    endtask

    // mode 0: plain frame; 1: extra start pulse mid-frame; 2: start raised in the done cycle only.
    task automatic run_frame(input logic [NB-1:0] pat, input int mode);
        bit pulsed = 1'b0;
        bit seen   = 1'b0;
        bit to     = 1'b1;
        clear_stats();
        exp_pat = pat;
        if (sel) grb2 = pat[NB2-1:0];
        else     grb  = pat;
        set_start(1'b1);
        for (int k = 0; k < 6000; k++) begin
            sample_cycle();
            set_start(1'b0);
            if (mode == 1 && rots == cur_nb / 2 && !pulsed) begin
                set_start(1'b1);
                pulsed = 1'b1;
            end
            if (mode == 2 && m_done) set_start(1'b1);
            if (m_busy) seen = 1'b1;
            else if (seen) begin
                to = 1'b0;
                break;
            end
        end
        check("frame_timeout", to, 0);
    endtask

    task automatic verify_frame(input string nm, input int exp_busy, input int e_ones,
                                input int e_first, input int e_last);
        bit reg_ok;
        reg_ok = sel ? (sr2 == exp_pat[NB2-1:0]) : (sr == exp_pat);
        check({nm, ".pulses"},     pulses,     cur_nb);
        check({nm, ".ones"},       ones,       e_ones);
        check({nm, ".first_w"},    first_w,    e_first);
        check({nm, ".last_w"},     last_w,     e_last);
        check({nm, ".width_err"},  width_err,  0);
        check({nm, ".period_err"}, period_err, 0);
        check({nm, ".rotates"},    rots,       cur_nb);
        check({nm, ".loads"},      loads,      1);
        check({nm, ".dones"},      dones,      1);
        check({nm, ".busy_len"},   busy_n,     exp_busy);
        check({nm, ".done_at"},    done_at,    exp_busy);
        check({nm, ".load_at"},    load_at,    1);
        check({nm, ".first_rise"}, first_rise, 3);
        check({nm, ".reg_restored"}, reg_ok,   1);
    endtask

    // Entered right after the first sampled cycle with reset still high.
    task automatic count_latch(input string nm, input int exp_len);
        int n  = 1;
        int d  = 0;
        bit to = 1'b1;
        reset = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (m_done) d++;
            if (!m_busy) begin
                to = 1'b0;
                break;
            end
            n++;
        end
        check({nm, ".timeout"}, to, 0);
        check({nm, ".latch_len"}, n, exp_len);
        check({nm, ".no_done"}, d, 0);
    endtask

    task automatic reset_mid(input logic [NB-1:0] pat);
        bit to = 1'b1;
        clear_stats();
        exp_pat = pat;
        grb     = pat;
        start   = 1'b1;
        for (int k = 0; k < 6000; k++) begin
            sample_cycle();
            start = 1'b0;
            if (rots == 30) begin
                to = 1'b0;
                break;
            end
        end
        check("rst_mid.reach_bit30", to, 0);
        repeat (3) sample_cycle();
        check("rst_mid.dout_before", m_dout, 1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid.dout_after", m_dout, 0);
        check("rst_mid.busy_after", m_busy, 1);
        check("rst_mid.rot_after",  m_rot,  0);
        count_latch("rst_mid", TR);
    endtask

    task automatic held_start();
        int runs = 0, run_err = 0, idle_err = 0, run_len = 0, idle_len = 0;
        bit prev = 1'b0;
        bit to   = 1'b1;
        clear_stats();
        exp_pat = '0;
        grb     = '0;
        start   = 1'b1;
        for (int k = 0; k < 15000; k++) begin
            sample_cycle();
            if (m_busy) begin
                if (!prev && runs > 0 && idle_len != 1) idle_err++;
                run_len++;
                idle_len = 0;
            end else begin
                if (prev) begin
                    runs++;
                    if (run_len != 1 + NB * TP + TR) run_err++;
                    run_len = 0;
                end
                idle_len++;
            end
            prev = m_busy;
            if (dones == 3 && !m_busy) begin
                start = 1'b0;
                to    = 1'b0;
                break;
            end
        end
        check("held.timeout",  to,       0);
        check("held.runs",     runs,     3);
        check("held.run_err",  run_err,  0);
        check("held.idle_err", idle_err, 0);
        check("held.loads",    loads,    3);
        check("held.dones",    dones,    3);
        check("held.gaps",     gaps,     2);
        check("held.gap_err",  gap_err,  0);
    endtask

    initial begin
        vecs[0] = '{{NB{1'b0}}, 0, T0, T0};
        vecs[1] = '{120'h800000_000000_000000_000000_000001, 2, T1, T1};
        vecs[2] = '{{NB{1'b1}}, NB, T1, T1};
        vecs[3] = '{{30{4'hA}}, 60, T1, T0};

        @(negedge clk);
        check("por.busy",  busy,  1);
        check("por.dout",  dout,  0);
        check("por.load",  load_register, 0);
        check("por.rot",   rotate_register_left, 0);
        check("por.done",  done,  0);
        check("por.busy2", busy2, 1);
        count_latch("por", TR);

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i].pat, 0);
            verify_frame($sformatf("vec%0d", i), 1 + NB * TP + TR,
                         vecs[i].ones, vecs[i].first_w, vecs[i].last_w);
        end

        run_frame(vecs[1].pat, 1);
        verify_frame("midstart", 1 + NB * TP + TR, 2, T1, T1);

        run_frame(vecs[0].pat, 2);
        verify_frame("donestart", 1 + NB * TP + TR, 0, T0, T0);
        clear_stats();
        repeat (5) sample_cycle();
        check("donestart.idle_busy",  busy_n, 0);
        check("donestart.idle_loads", loads,  0);

        reset_mid(vecs[1].pat);
        run_frame(vecs[3].pat, 0);
        verify_frame("after_rst", 1 + NB * TP + TR, 60, T1, T0);

        held_start();

        sel = 1'b1;
        repeat (2) @(negedge clk);
        run_frame(120'h800001, 0);
        verify_frame("p24", 1 + NB2 * TP2 + TR2, 2, T12, T12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
